l2_cache_sched: RTL and testbench
=================================

Name: l2_cache_sched

Overview:
- Scheduler that sequences the 16x4096 / 128x512 L2 cache buffer.
- DDR side: issues refill bursts of 128-bit beats when L2 occupancy drops below a low-water mark.
- L1 side: admits L1 read/write transfers only when enough data or space exists.
- Conflicts: while the L2 flags an L1/DDR address overlap, DDR write beats are held off.
- Drives the L2's i_l1_operate_enable/i_l1_rw and i_ddr_operate_enable/i_ddr_rw, and consumes its o_l2_unread_size and o_l1ddr_rw_confilicts.

Parameters:
- BURST_BEATS, 4, 128-bit beats per DDR refill burst (1..16); equals BURST_BEATS*8 16-bit words.
- LOW_WATER, 256, refill is requested when unread size < LOW_WATER (16-bit words).
- TIMEOUT_CYCLES, 1024, DDR ack/beat watchdog limit (only with the optional feature).

Ports:
- clk_166M66  in  1  system clock, 166.66 MHz.
- mcu_sys_rst_n  in  1  reset; asynchronous assert, active-low.
- i_l2_unread_size  in  12  valid 16-bit words held in L2.
- i_l1ddr_rw_conflicts  in  1  L1/DDR address overlap flag from L2.
- i_l1_req  in  1  L1 transfer request; held until o_l1_gnt.
- i_l1_rw  in  1  1 = L1 writes into L2, 0 = L1 reads from L2; sampled with i_l1_req.
- i_l1_len  in  8  transfer length in 16-bit words; sampled at grant.
- o_l1_gnt  out  1  one-cycle grant pulse.
- o_l1_operate_enable  out  1  per-word L1 strobe to L2.
- o_l1_rw  out  1  direction to L2, latched at grant.
- o_l1_done  out  1  one-cycle pulse after the last word.
- o_ddr_req  out  1  refill burst request to the DDR controller.
- i_ddr_ack  in  1  burst accepted; one-cycle pulse.
- i_ddr_valid  in  1  one 128-bit beat present on the DDR data bus.
- o_ddr_operate_enable  out  1  per-beat DDR strobe to L2.
- o_ddr_rw  out  1  constant 1 (DDR writes L2).
- o_ddr_stall  out  1  beat refused this cycle; DDR controller must hold the beat.
- o_ddr_timeout  out  1  one-cycle watchdog pulse.

Behaviour:
Reset:
- All outputs 0 except o_ddr_rw = 1.
- Both FSMs go to IDLE and all counters clear immediately on assertion, including mid-burst or mid-transfer.
- No completion pulse is generated for an operation cut off by reset.

Arithmetic:
- free = 12'hFFF - i_l2_unread_size (12-bit, no wrap).
- All comparisons are unsigned.

DDR FSM (D_IDLE, D_REQ, D_BEAT, D_DONE):
- D_IDLE -> D_REQ when i_l2_unread_size < LOW_WATER and free >= BURST_BEATS*8.
- D_REQ:
  - o_ddr_req = 1.
  - On i_ddr_ack, clear beat_cnt and go to D_BEAT; o_ddr_req drops the cycle after ack.
- D_BEAT:
  - o_ddr_operate_enable = i_ddr_valid & ~i_l1ddr_rw_conflicts (combinational, same cycle).
  - o_ddr_stall = i_ddr_valid & i_l1ddr_rw_conflicts.
  - beat_cnt increments only on accepted beats.
  - After BURST_BEATS accepted beats, go to D_DONE.
- D_DONE: one cycle, then D_IDLE. This gap gives the L2 one cycle to update the unread count before a new refill decision.
- i_ddr_valid outside D_BEAT is ignored; no strobe is issued.

L1 FSM (L_IDLE, L_XFER, L_DONE):
- Admission from L_IDLE with i_l1_req:
  - Read (i_l1_rw = 0) needs i_l2_unread_size >= i_l1_len.
  - Write needs free >= i_l1_len.
  - Otherwise the request waits with no grant.
- On admission:
  - o_l1_gnt pulses.
  - o_l1_rw and word count are latched.
  - Go to L_XFER, or straight to L_DONE if len = 0.
- L_XFER:
  - o_l1_operate_enable = 1 every cycle for exactly len cycles; no stalls.
  - The first strobe is in the cycle after the grant.
- L_DONE: o_l1_done pulses for one cycle, then L_IDLE.
- The next grant is possible the cycle after done.

Simultaneous events:
- The two FSMs run concurrently (dual-port RAM).
- When a conflict is flagged, the L1 side always proceeds and the DDR beat is stalled.
- A refill decision and an L1 admission in the same cycle both use the same sampled i_l2_unread_size.
- Boundaries:
  - unread = 0: refill is allowed and L1 reads of len >= 1 block.
  - unread = 12'hFFF: free = 0, so refill and any L1 write of len >= 1 block.

Optional Feature:
Macro L2_SCHED_DDR_TIMEOUT_EN.
- Defined:
  - A counter runs in D_REQ (waiting for ack) and in D_BEAT (since the last accepted beat; stalled cycles do not count).
  - On reaching TIMEOUT_CYCLES, o_ddr_timeout pulses for one cycle and the FSM returns to D_IDLE.
  - o_ddr_req drops and partial beats are abandoned.
- Undefined: no counter; the FSM waits indefinitely and o_ddr_timeout is tied 0.

Test Plan:
1. Reset released with unread = 0 -> o_ddr_req = 1 next cycle; ack, then 4 valid beats -> 4 strobe cycles; D_DONE; o_ddr_req drops.
2. unread = 300 (>= LOW_WATER) -> o_ddr_req stays 0; then set unread = 255 -> o_ddr_req = 1 within 1 cycle.
3. L1 read, len = 16, unread = 10 -> no grant; raise unread to 16 -> o_l1_gnt, 16 consecutive o_l1_operate_enable with o_l1_rw = 0, then o_l1_done.
4. During D_BEAT, drive valid with conflict = 1 for 3 cycles -> o_ddr_stall = 1 and enable = 0 for those cycles; beat count unchanged; burst still ends after 4 accepted beats.
5. unread = 12'hFFF -> no refill; an L1 write with len = 1 waits; an L1 read with len = 8 is granted. Reset asserted mid-transfer -> all outputs 0 immediately and no o_l1_done.
6. With L2_SCHED_DDR_TIMEOUT_EN and TIMEOUT_CYCLES = 8: withhold ack -> o_ddr_timeout pulse 8 cycles after o_ddr_req rises, FSM returns to D_IDLE. Without the macro, o_ddr_req stays high 100 cycles and o_ddr_timeout stays 0.

Source files
------------

// File: rtl/l2_cache_sched_if.sv
// L1/DDR/L2 handshake bundle around the L2 buffer scheduler.
// master = scheduler side, slave = L1 / DDR / L2 side.
interface l2_cache_sched_if;
    logic [11:0] i_l2_unread_size;
    logic        i_l1ddr_rw_conflicts;
    logic        i_l1_req;
    logic        i_l1_rw;
    logic [7:0]  i_l1_len;
    logic        o_l1_gnt;
    logic        o_l1_operate_enable;
    logic        o_l1_rw;
    logic        o_l1_done;
    logic        o_ddr_req;
    logic        i_ddr_ack;
    logic        i_ddr_valid;
    logic        o_ddr_operate_enable;
    logic        o_ddr_rw;
    logic        o_ddr_stall;
    logic        o_ddr_timeout;

    modport master (
        input  i_l2_unread_size, i_l1ddr_rw_conflicts,
        input  i_l1_req, i_l1_rw, i_l1_len,
        input  i_ddr_ack, i_ddr_valid,
        output o_l1_gnt, o_l1_operate_enable, o_l1_rw, o_l1_done,
        output o_ddr_req, o_ddr_operate_enable, o_ddr_rw,
        output o_ddr_stall, o_ddr_timeout
    );

    modport slave (
        output i_l2_unread_size, i_l1ddr_rw_conflicts,
        output i_l1_req, i_l1_rw, i_l1_len,
        output i_ddr_ack, i_ddr_valid,
        input  o_l1_gnt, o_l1_operate_enable, o_l1_rw, o_l1_done,
        input  o_ddr_req, o_ddr_operate_enable, o_ddr_rw,
        input  o_ddr_stall, o_ddr_timeout
    );
endinterface

// File: rtl/l2_cache_sched.sv
// L2 buffer scheduler: DDR refill FSM and L1 admission FSM.
// Optional DDR watchdog: define L2_SCHED_DDR_TIMEOUT_EN.
module l2_cache_sched #(
    parameter int BURST_BEATS    = 4,
    parameter int LOW_WATER      = 256,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input logic               clk_166M66,
    input logic               mcu_sys_rst_n,
    l2_cache_sched_if.master  bus
);
    typedef enum logic [1:0] {D_IDLE, D_REQ, D_BEAT, D_DONE} ddr_state_t;
    typedef enum logic [1:0] {L_IDLE, L_XFER, L_DONE} l1_state_t;

    ddr_state_t d_state, d_next;
    l1_state_t  l_state, l_next;

    logic [11:0] unread;
    logic [11:0] free;
    logic        refill_ok;
    logic        admit;
    logic        beat_acc;
    logic        beat_hold;
    logic        last_beat;
    logic        wd_expire;
    logic [4:0]  beat_cnt;
    logic [7:0]  word_cnt;
    logic [7:0]  len_q;
    logic        rw_q;

    logic ddr_req, ddr_en, ddr_stall;
    logic l1_gnt, l1_en, l1_done;

    assign unread    = bus.i_l2_unread_size;
    assign free      = 12'hFFF - unread;
    assign refill_ok = (32'(unread) < 32'(LOW_WATER))
                    && (32'(free) >= 32'(BURST_BEATS * 8));
    assign admit     = bus.i_l1_rw ? (free >= {4'b0, bus.i_l1_len})
                                   : (unread >= {4'b0, bus.i_l1_len});
    assign beat_acc  = bus.i_ddr_valid & ~bus.i_l1ddr_rw_conflicts;
    assign beat_hold = bus.i_ddr_valid & bus.i_l1ddr_rw_conflicts;
    assign last_beat = beat_cnt == 5'(BURST_BEATS - 1);

    // DDR state register
    always_ff @(posedge clk_166M66 or negedge mcu_sys_rst_n) begin
        if (!mcu_sys_rst_n) d_state <= D_IDLE;
        else                d_state <= d_next;
    end

    // DDR next state and strobes
    always_comb begin
        d_next    = d_state;
        ddr_req   = 1'b0;
        ddr_en    = 1'b0;
        ddr_stall = 1'b0;
        unique case (d_state)
            D_IDLE: if (refill_ok) d_next = D_REQ;
            D_REQ: begin
                ddr_req = 1'b1;
                if (bus.i_ddr_ack) d_next = D_BEAT;
                else if (wd_expire) d_next = D_IDLE;
            end
            D_BEAT: begin
                ddr_en    = beat_acc;
                ddr_stall = beat_hold;
                if (beat_acc && last_beat) d_next = D_DONE;
                else if (wd_expire) d_next = D_IDLE;
            end
            D_DONE: d_next = D_IDLE;
            default: d_next = D_IDLE;
        endcase
    end

    // Accepted-beat counter, cleared whenever no burst is in flight
    always_ff @(posedge clk_166M66 or negedge mcu_sys_rst_n) begin
        if (!mcu_sys_rst_n) beat_cnt <= '0;
        else if (d_state != D_BEAT) beat_cnt <= '0;
        else if (beat_acc) beat_cnt <= beat_cnt + 5'd1;
    end

`ifdef L2_SCHED_DDR_TIMEOUT_EN
    logic [31:0] wd_cnt;
    logic        to_q;

    assign wd_expire =
        ((d_state == D_REQ && !bus.i_ddr_ack)
      || (d_state == D_BEAT && !bus.i_ddr_valid))
      && (wd_cnt == 32'(TIMEOUT_CYCLES - 1));

    // Watchdog: idle waits count, stalled beats freeze it
    always_ff @(posedge clk_166M66 or negedge mcu_sys_rst_n) begin
        if (!mcu_sys_rst_n) begin
            wd_cnt <= '0;
            to_q   <= 1'b0;
        end else begin
            to_q <= wd_expire;
            unique case (d_state)
                D_REQ:
                    wd_cnt <= bus.i_ddr_ack ? '0 : wd_cnt + 32'd1;
                D_BEAT:
                    if (beat_acc) wd_cnt <= '0;
                    else if (!bus.i_ddr_valid) wd_cnt <= wd_cnt + 32'd1;
                default: wd_cnt <= '0;
            endcase
        end
    end

    assign bus.o_ddr_timeout = to_q;
`else
    assign wd_expire         = 1'b0;
    assign bus.o_ddr_timeout = 1'b0;
`endif

    // L1 state register
    always_ff @(posedge clk_166M66 or negedge mcu_sys_rst_n) begin
        if (!mcu_sys_rst_n) l_state <= L_IDLE;
        else                l_state <= l_next;
    end

    // L1 admission, strobe and done generation
    always_comb begin
        l_next  = l_state;
        l1_gnt  = 1'b0;
        l1_en   = 1'b0;
        l1_done = 1'b0;
        unique case (l_state)
            L_IDLE:
                if (mcu_sys_rst_n && bus.i_l1_req && admit) begin
                    l1_gnt = 1'b1;
                    l_next = (bus.i_l1_len == 8'd0) ? L_DONE : L_XFER;
                end
            L_XFER: begin
                l1_en = 1'b1;
                if (word_cnt == len_q - 8'd1) l_next = L_DONE;
            end
            L_DONE: begin
                l1_done = 1'b1;
                l_next  = L_IDLE;
            end
            default: l_next = L_IDLE;
        endcase
    end

    // Latch direction/length at grant and count issued words
    always_ff @(posedge clk_166M66 or negedge mcu_sys_rst_n) begin
        if (!mcu_sys_rst_n) begin
            rw_q     <= 1'b0;
            len_q    <= '0;
            word_cnt <= '0;
        end else begin
            if (l1_gnt) begin
                rw_q  <= bus.i_l1_rw;
                len_q <= bus.i_l1_len;
            end
            if (l_state == L_XFER) word_cnt <= word_cnt + 8'd1;
            else                   word_cnt <= '0;
        end
    end

    assign bus.o_ddr_req            = ddr_req;
    assign bus.o_ddr_operate_enable = ddr_en;
    assign bus.o_ddr_stall          = ddr_stall;
    assign bus.o_ddr_rw             = 1'b1;
    assign bus.o_l1_gnt             = l1_gnt;
    assign bus.o_l1_operate_enable  = l1_en;
    assign bus.o_l1_rw              = rw_q;
    assign bus.o_l1_done            = l1_done;
endmodule

// File: tb/tb_l2_cache_sched.sv
// Bench for l2_cache_sched: transaction-level model plus directed tests.
// Build with L2_SCHED_DDR_TIMEOUT_EN to exercise the watchdog path.
module tb_l2_cache_sched;
    localparam int BEATS = 4;
    localparam int LW    = 256;
    localparam int TO    = 8;
`ifdef L2_SCHED_DDR_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    l2_cache_sched_if bus ();

    l2_cache_sched #(
        .BURST_BEATS    (BEATS),
        .LOW_WATER      (LW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk_166M66    (clk),
        .mcu_sys_rst_n (rst_n),
        .bus           (bus)
    );

    initial clk = 1'b0;
    always #3 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h, wanted %0h",
                     nm, $time, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Model state: outstanding DDR work and L1 words left
    bit m_req;
    int m_left;
    bit m_gap;
    int m_wd;
    bit m_to;
    int l_left;
    bit l_done;
    bit l_rw;
    bit acc;
    bit ok;
    int u;

    function automatic bit admit_f(int unread, bit rw, int len);
        if (rw) return (4095 - unread) >= len;
        return unread >= len;
    endfunction

    // Advance the model once per clock from pre-edge inputs
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_req = 0; m_left = 0; m_gap = 0; m_wd = 0; m_to = 0;
            l_left = 0; l_done = 0; l_rw = 0;
        end else begin
            u   = int'(bus.i_l2_unread_size);
            acc = bus.i_ddr_valid && !bus.i_l1ddr_rw_conflicts;
            ok  = bus.i_l1_req
               && admit_f(u, bus.i_l1_rw, int'(bus.i_l1_len));
            m_to = 0;
            if (m_req) begin
                if (bus.i_ddr_ack) begin
                    m_req = 0; m_left = BEATS; m_wd = 0;
                end else begin
                    m_wd++;
                    if (TO_EN && m_wd == TO) begin
                        m_req = 0; m_to = 1; m_wd = 0;
                    end
                end
            end else if (m_left > 0) begin
                if (acc) begin
                    m_left--; m_wd = 0;
                    if (m_left == 0) m_gap = 1;
                end else if (!bus.i_ddr_valid) begin
                    m_wd++;
                    if (TO_EN && m_wd == TO) begin
                        m_left = 0; m_to = 1; m_wd = 0;
                    end
                end
            end else if (m_gap) begin
                m_gap = 0;
            end else if (u < LW && 4095 - u >= BEATS * 8) begin
                m_req = 1; m_wd = 0;
            end

            if (l_done) begin
                l_done = 0;
            end else if (l_left > 0) begin
                l_left--;
                if (l_left == 0) l_done = 1;
            end else if (ok) begin
                l_rw = bus.i_l1_rw;
                if (bus.i_l1_len == 0) l_done = 1;
                else l_left = int'(bus.i_l1_len);
            end
        end
    end

    // Compare every output against the model on each falling edge
    always @(negedge clk) begin
        bit burst;
        bit l_idle;
        burst  = m_left > 0;
        l_idle = (l_left == 0) && !l_done;
        chk("ddr_req", bus.o_ddr_req, m_req);
        chk("ddr_en", bus.o_ddr_operate_enable,
            burst && bus.i_ddr_valid && !bus.i_l1ddr_rw_conflicts);
        chk("ddr_stall", bus.o_ddr_stall,
            burst && bus.i_ddr_valid && bus.i_l1ddr_rw_conflicts);
        chk("ddr_rw", bus.o_ddr_rw, 1);
        chk("ddr_timeout", bus.o_ddr_timeout, m_to);
        chk("l1_gnt", bus.o_l1_gnt,
            rst_n && l_idle && bus.i_l1_req
            && admit_f(int'(bus.i_l2_unread_size), bus.i_l1_rw,
                       int'(bus.i_l1_len)));
        chk("l1_en", bus.o_l1_operate_enable, l_left > 0);
        chk("l1_rw", bus.o_l1_rw, l_rw);
        chk("l1_done", bus.o_l1_done, l_done);
    end

    int n;
    int rwbad;
    bit seen;

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        bus.i_l2_unread_size     = 12'd0;
        bus.i_l1ddr_rw_conflicts = 1'b0;
        bus.i_l1_req             = 1'b0;
        bus.i_l1_rw              = 1'b0;
        bus.i_l1_len             = 8'd0;
        bus.i_ddr_ack            = 1'b0;
        bus.i_ddr_valid          = 1'b0;
        repeat (3) cyc();

        @(negedge clk);
        chk("rst_ddr_req", bus.o_ddr_req, 0);
        chk("rst_ddr_rw", bus.o_ddr_rw, 1);
        chk("rst_l1_gnt", bus.o_l1_gnt, 0);
        chk("rst_l1_rw", bus.o_l1_rw, 0);

        // 1: refill from empty, four clean beats
        cyc(); rst_n = 1'b1;
        cyc();
        @(negedge clk); chk("t1_req_rise", bus.o_ddr_req, 1);
        cyc(); bus.i_ddr_ack = 1'b1; bus.i_l2_unread_size = 12'd300;
        cyc(); bus.i_ddr_ack = 1'b0; bus.i_ddr_valid = 1'b1;
        n = 0;
        repeat (4) begin
            @(negedge clk); n += int'(bus.o_ddr_operate_enable);
            cyc();
        end
        bus.i_ddr_valid = 1'b0;
        chk("t1_beats", n, 4);
        @(negedge clk); chk("t1_req_drop", bus.o_ddr_req, 0);

        // 2: above low water, then just below
        repeat (3) begin
            cyc(); @(negedge clk); chk("t2_no_refill", bus.o_ddr_req, 0);
        end
        cyc(); bus.i_l2_unread_size = 12'd255;
        cyc(); @(negedge clk); chk("t2_refill", bus.o_ddr_req, 1);

        // 4: conflict stalls three beats, burst still needs four
        cyc(); bus.i_ddr_ack = 1'b1;
        cyc(); bus.i_ddr_ack = 1'b0;
        bus.i_ddr_valid = 1'b1; bus.i_l1ddr_rw_conflicts = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("t4_stall", bus.o_ddr_stall, 1);
            chk("t4_no_en", bus.o_ddr_operate_enable, 0);
            cyc();
        end
        bus.i_l1ddr_rw_conflicts = 1'b0;
        bus.i_l2_unread_size = 12'd300;
        n = 0;
        repeat (4) begin
            @(negedge clk); n += int'(bus.o_ddr_operate_enable);
            cyc();
        end
        bus.i_ddr_valid = 1'b0;
        chk("t4_beats", n, 4);
        @(negedge clk); chk("t4_req_drop", bus.o_ddr_req, 0);

        // 3: read blocked until enough data, then 16 words
        cyc();
        bus.i_l2_unread_size = 12'd10;
        bus.i_l1_req = 1'b1; bus.i_l1_rw = 1'b0; bus.i_l1_len = 8'd16;
        repeat (3) begin
            @(negedge clk); chk("t3_wait", bus.o_l1_gnt, 0);
            cyc();
        end
        bus.i_l2_unread_size = 12'd16;
        @(negedge clk); chk("t3_gnt", bus.o_l1_gnt, 1);
        cyc(); bus.i_l1_req = 1'b0;
        n = 0; rwbad = 0; seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (bus.o_l1_operate_enable) begin
                n++;
                if (bus.o_l1_rw !== 1'b0) rwbad++;
            end
            if (bus.o_l1_done) seen = 1;
            cyc();
        end
        chk("t3_words", n, 16);
        chk("t3_done", seen, 1);
        chk("t3_rw", rwbad, 0);

        // 5: full L2, write blocked, read granted, reset mid-transfer
        rst_n = 1'b0; bus.i_l2_unread_size = 12'hFFF;
        cyc(); cyc(); rst_n = 1'b1;
        cyc();
        repeat (3) begin
            @(negedge clk); chk("t5_no_refill", bus.o_ddr_req, 0);
            cyc();
        end
        bus.i_l1_req = 1'b1; bus.i_l1_rw = 1'b1; bus.i_l1_len = 8'd1;
        repeat (3) begin
            @(negedge clk); chk("t5_wr_wait", bus.o_l1_gnt, 0);
            cyc();
        end
        bus.i_l1_rw = 1'b0; bus.i_l1_len = 8'd8;
        @(negedge clk); chk("t5_rd_gnt", bus.o_l1_gnt, 1);
        cyc(); bus.i_l1_req = 1'b0;
        repeat (3) begin
            @(negedge clk); chk("t5_strobe", bus.o_l1_operate_enable, 1);
            cyc();
        end
        rst_n = 1'b0;
        #1;
        chk("t5_rst_en", bus.o_l1_operate_enable, 0);
        chk("t5_rst_done", bus.o_l1_done, 0);
        chk("t5_rst_rw", bus.o_ddr_rw, 1);
        seen = 0;
        repeat (4) cyc();
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.o_l1_done) seen = 1;
            cyc();
        end
        chk("t5_no_done", seen, 0);

        // 6: ack withheld
        rst_n = 1'b0; bus.i_l2_unread_size = 12'd0;
        cyc(); rst_n = 1'b1;
        cyc();
        @(negedge clk); chk("t6_req", bus.o_ddr_req, 1);
`ifdef L2_SCHED_DDR_TIMEOUT_EN
        n = 0; seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            cyc(); @(negedge clk); n++;
            if (bus.o_ddr_timeout) seen = 1;
        end
        chk("t6_timeout", seen, 1);
        chk("t6_to_delay", n, 8);
        chk("t6_req_drop", bus.o_ddr_req, 0);
`else
        n = 0; rwbad = 0;
        repeat (100) begin
            cyc(); @(negedge clk);
            if (bus.o_ddr_req) n++;
            if (bus.o_ddr_timeout) rwbad++;
        end
        chk("t6_req_hold", n, 100);
        chk("t6_no_to", rwbad, 0);
`endif

        cyc();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
